// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, SPI mode constants and width helpers shared by spi_master_cfg.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_e;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Index width for n items that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // Width of the chip-select index port.
    function automatic int unsigned cs_idx_w(input int unsigned num_cs);
        return idx_w(num_cs);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK half-period divider and edge counter; emits leading/trailing/last edge strobes.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic lead_edge_c_o,
    output logic trail_edge_c_o,
    output logic last_edge_c_o
);

    localparam int unsigned DIV_W  = idx_w(CLK_DIV);
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              tick_c;

    // Divider advances while enabled; every terminal count is one SCLK edge.
    always_comb begin
        tick_c = en_i && (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = div_q;
        edge_d = edge_q;
        if (!en_i) begin
            div_d  = '0;
            edge_d = '0;
        end else if (tick_c) begin
            div_d  = '0;
            edge_d = edge_q + EDGE_W'(1);
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            edge_q <= '0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
        end
    end

    // Edges completed so far: even count -> next edge is leading, odd -> trailing.
    assign lead_edge_c_o  = tick_c && !edge_q[0];
    assign trail_edge_c_o = tick_c && edge_q[0];
    assign last_edge_c_o  = tick_c && (edge_q == EDGE_W'(2 * DATA_W - 1));

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised full-duplex SPI master, all CPOL/CPHA modes, NUM_CS active-low selects.
// Build option: define SPI_LOOPBACK_EN to sample the registered mosi instead of the miso port.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_CS  = 4,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic [cs_idx_w(NUM_CS)-1:0] cs_sel,
    input  logic                        cpol,
    input  logic                        cpha,
    output logic                        rx_valid,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        busy,
    output logic                        sclk,
    output logic                        mosi,
    input  logic                        miso,
    output logic [NUM_CS-1:0]           cs_n
);

    localparam int unsigned CS_W  = cs_idx_w(NUM_CS);
    localparam int unsigned DIV_W = idx_w(CLK_DIV);

    spi_state_e        state_q;
    logic [DATA_W-1:0] tx_sr_q, rx_sr_q, rx_data_q;
    logic [DIV_W-1:0]  cnt_q;
    logic              cpol_q, cpha_q, sclk_q, mosi_q;
    logic              rx_valid_q, busy_q, tx_ready_q;
    logic [NUM_CS-1:0] cs_n_q, cs_dec_c;
    logic              lead_c, trail_c, last_c, sample_c, shift_c, in_bit_c, phase_end_c;

    spi_clk_gen #(
        .DATA_W (DATA_W),
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk           (clk),
        .rst           (rst),
        .en_i          (state_q == SHIFT),
        .lead_edge_c_o (lead_c),
        .trail_edge_c_o(trail_c),
        .last_edge_c_o (last_c)
    );

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign in_bit_c    = mosi_q;
`else
    assign in_bit_c    = miso;
`endif

    assign phase_end_c = (cnt_q == DIV_W'(CLK_DIV - 1));

    // One-hot active-low select; an out-of-range index asserts nothing.
    always_comb begin
        cs_dec_c = '1;
        for (int i = 0; i < int'(NUM_CS); i++) begin
            if (cs_sel == CS_W'(i)) cs_dec_c[i] = 1'b0;
        end
    end

    // Map SCLK edges to sample/shift actions for the latched mode; no shift after the final bit.
    always_comb begin
        sample_c = 1'b0;
        shift_c  = 1'b0;
        case ({cpol_q, cpha_q})
            SPI_MODE0, SPI_MODE2: begin
                sample_c = lead_c;
                shift_c  = trail_c && !last_c;
            end
            SPI_MODE1, SPI_MODE3: begin
                sample_c = trail_c;
                shift_c  = lead_c;
            end
            default: ;
        endcase
    end

    // Transfer sequencer: handshake, chip select, SCLK level, shifting and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            cnt_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    if (tx_valid && tx_ready_q) begin
                        state_q    <= SETUP;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
                        cpol_q     <= cpol;
                        cpha_q     <= cpha;
                        cs_n_q     <= cs_dec_c;
                        cnt_q      <= '0;
                        rx_sr_q    <= '0;
                        if (!cpha) begin
                            mosi_q  <= tx_data[DATA_W-1];
                            tx_sr_q <= {tx_data[DATA_W-2:0], 1'b0};
                        end else begin
                            tx_sr_q <= tx_data;
                        end
                    end
                end
                SETUP: begin
                    cnt_q <= phase_end_c ? '0 : cnt_q + DIV_W'(1);
                    if (phase_end_c) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (lead_c || trail_c) sclk_q <= ~sclk_q;
                    if (sample_c) rx_sr_q <= {rx_sr_q[DATA_W-2:0], in_bit_c};
                    if (shift_c) begin
                        mosi_q  <= tx_sr_q[DATA_W-1];
                        tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                    end
                    if (last_c) state_q <= HOLD;
                end
                HOLD: begin
                    sclk_q <= cpol_q;
                    cnt_q  <= phase_end_c ? '0 : cnt_q + DIV_W'(1);
                    if (phase_end_c) state_q <= DONE;
                end
                DONE: begin
                    cs_n_q     <= '1;
                    rx_data_q  <= rx_sr_q;
                    rx_valid_q <= 1'b1;
                    busy_q     <= 1'b0;
                    tx_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Testbench for spi_master_cfg: table vectors, random transfers against a behavioural SPI slave,
// back-to-back / ignored-request sequence and asynchronous reset mid-transfer.
module tb_spi_master_cfg;

`ifdef SPI_LOOPBACK_EN
    localparam int W = 8;
    localparam int D = 1;
`else
    localparam int W = 32;
    localparam int D = 4;
`endif
    localparam int NCS      = 3;
    localparam int CS_W     = (NCS > 1) ? $clog2(NCS) : 1;
    localparam int LAT      = (2 * W + 2) * D + 1;
    localparam int RST_EDGE = (2 * W > 20) ? 20 : W;

    logic            clk      = 1'b0;
    logic            rst      = 1'b0;
    logic            tx_valid = 1'b0;
    logic            tx_ready;
    logic [W-1:0]    tx_data  = '0;
    logic [CS_W-1:0] cs_sel   = '0;
    logic            cpol     = 1'b0;
    logic            cpha     = 1'b0;
    logic            rx_valid;
    logic [W-1:0]    rx_data;
    logic            busy, sclk, mosi;
    logic            miso     = 1'b1;
    logic [NCS-1:0]  cs_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master_cfg #(
        .DATA_W (W),
        .NUM_CS (NCS),
        .CLK_DIV(D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .cs_sel  (cs_sel),
        .cpol    (cpol),
        .cpha    (cpha),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .busy    (busy),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Behavioural SPI slave: active while any cs_n line is low, samples mosi on the mode's
    // sample edge, presents its word MSB first on the other edge. Miso idles high.
    logic [W-1:0] s_word = '0;
    logic [W-1:0] s_rx   = '0;
    logic [W-1:0] s_q[$];
    bit           m_cpha = 1'b0;
    bit           s_act  = 1'b0;
    logic         s_prev = 1'b0;
    int           s_ti   = 0;
    int           s_nedge = 0;

    always @(sclk or cs_n) begin
        if (cs_n != '1 && cs_n !== 'x && !s_act) begin
            s_act   = 1'b1;
            s_rx    = '0;
            s_nedge = 0;
            s_ti    = 0;
            s_prev  = sclk;
            if (!m_cpha) begin
                miso = s_word[W-1];
                s_ti = 1;
            end
        end else if (cs_n == '1 && s_act) begin
            s_act = 1'b0;
            s_q.push_back(s_rx);
            miso  = 1'b1;
        end else if (s_act && sclk !== s_prev) begin
            s_prev = sclk;
            s_nedge++;
            if (((s_nedge % 2) == 1) ^ m_cpha) begin
                s_rx = {s_rx[W-2:0], mosi};
            end else if (s_ti < W) begin
                miso = s_word[W-1-s_ti];
                s_ti++;
            end
        end
    end

    // Count rx_valid pulses and record every cs_n-high gap between two selected periods.
    int  rx_cnt   = 0;
    int  hi_run   = 0;
    bit  seen_low = 1'b0;
    int  gaps[$];

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_cnt++;
        if (cs_n === '1) begin
            hi_run++;
        end else begin
            if (seen_low && hi_run > 0) gaps.push_back(hi_run);
            seen_low = 1'b1;
            hi_run   = 0;
        end
    end

    // One complete transfer with expectations derived from the slave word and selection.
    task automatic xfer(input logic [W-1:0] tx, input logic [W-1:0] sw, input int cs,
                        input bit cp, input bit ch, input logic [NCS-1:0] exp_cs);
        logic [W-1:0] exp_rx;
        int           cyc;
        int           s_base;
        bit           cs_ok, busy_ok;
`ifdef SPI_LOOPBACK_EN
        exp_rx = tx;
`else
        exp_rx = (cs < NCS) ? sw : '1;
`endif
        cyc = 0;
        while (tx_ready !== 1'b1 && cyc < 2 * LAT) begin
            @(posedge clk); #1; cyc++;
        end
        @(negedge clk);
        cpol   = cp;
        cpha   = ch;
        m_cpha = ch;
        s_word = sw;
        @(negedge clk);
        s_base   = s_q.size();
        tx_valid = 1'b1;
        tx_data  = tx;
        cs_sel   = CS_W'(cs);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("sclk_idle_before", 64'(sclk), 64'(cp));
        cs_ok   = 1'b1;
        busy_ok = 1'b1;
        cyc     = 0;
        while (rx_valid !== 1'b1 && cyc < LAT + 20) begin
            if (cs_n !== exp_cs) cs_ok = 1'b0;
            if (busy !== 1'b1 || tx_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1; cyc++;
        end
        check("latency", 64'(cyc), 64'(LAT));
        check("rx_data", 64'(rx_data), 64'(exp_rx));
        check("cs_n_during", 64'(cs_ok), 64'(1));
        check("busy_ready_during", 64'(busy_ok), 64'(1));
        check("cs_n_after", 64'(cs_n), 64'({NCS{1'b1}}));
        check("sclk_idle_after", 64'(sclk), 64'(cp));
        if (cs < NCS) begin
            check("slave_words", 64'(s_q.size() - s_base), 64'(1));
            if (s_q.size() > s_base) check("slave_rx", 64'(s_q[s_base]), 64'(tx));
            check("sclk_edges", 64'(s_nedge), 64'(2 * W));
        end else begin
            check("no_slave_select", 64'(s_q.size() - s_base), 64'(0));
        end
        @(posedge clk); #1;
        check("rx_valid_pulse", 64'(rx_valid), 64'(0));
    endtask

    typedef struct {
        logic [31:0]    tx;
        logic [31:0]    sw;
        int             cs;
        bit             cpol;
        bit             cpha;
        logic [NCS-1:0] exp_cs;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [W-1:0]   tx, sw;
        logic [NCS-1:0] ecs;
        int             cs, cyc, snap, s_base, g_base;
        bit             cp, ch;

        vecs[0] = '{32'hA5A50F0F, 32'h3C3C1234, 0, 1'b0, 1'b0, 3'b110};
        vecs[1] = '{32'hA5A50F0F, 32'h3C3C1234, 1, 1'b0, 1'b1, 3'b101};
        vecs[2] = '{32'hA5A50F0F, 32'h3C3C1234, 2, 1'b1, 1'b0, 3'b011};
        vecs[3] = '{32'hA5A50F0F, 32'h3C3C1234, 0, 1'b1, 1'b1, 3'b110};
        vecs[4] = '{32'h000000C3, 32'h0000003C, 1, 1'b1, 1'b0, 3'b101};
        vecs[5] = '{32'hFFFF0000, 32'h0000FFFF, 3, 1'b0, 1'b1, 3'b111};
        vecs[6] = '{32'h000000C3, 32'h81818181, 2, 1'b1, 1'b1, 3'b011};

        // Reset values.
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sclk", 64'(sclk), 64'(0));
        check("reset_mosi", 64'(mosi), 64'(0));
        check("reset_cs_n", 64'(cs_n), 64'({NCS{1'b1}}));
        check("reset_rx_valid", 64'(rx_valid), 64'(0));
        check("reset_rx_data", 64'(rx_data), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_tx_ready", 64'(tx_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Table vectors: all four modes, chip-select decode, out-of-range select.
        for (int i = 0; i < 7; i++) begin
            xfer(W'(vecs[i].tx), W'(vecs[i].sw), vecs[i].cs, vecs[i].cpol, vecs[i].cpha, vecs[i].exp_cs);
        end

        // Randomised transfers.
        for (int i = 0; i < 12; i++) begin
            tx  = W'($urandom);
            sw  = W'($urandom);
            cs  = int'($urandom_range(0, NCS));
            cp  = 1'($urandom_range(0, 1));
            ch  = 1'($urandom_range(0, 1));
            ecs = '1;
            if (cs < NCS) ecs[cs] = 1'b0;
            xfer(tx, sw, cs, cp, ch, ecs);
        end

        // tx_valid held across two words, then a pulse while busy that must be ignored.
        @(negedge clk);
        cpol   = 1'b0;
        cpha   = 1'b0;
        m_cpha = 1'b0;
        s_word = W'(32'h5A5AC3C3);
        cs_sel = CS_W'(0);
        @(negedge clk);
        snap     = rx_cnt;
        s_base   = s_q.size();
        tx_valid = 1'b1;
        tx_data  = W'(32'h11111111);
        @(posedge clk); #1;
        g_base = gaps.size();
        check("b2b_ready_low", 64'(tx_ready), 64'(0));
        @(negedge clk);
        tx_data = W'(32'h22222222);
        cyc = 0;
        while (rx_valid !== 1'b1 && cyc < LAT + 20) begin
            @(posedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        check("b2b_second_accept", 64'(busy), 64'(1));
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (LAT / 2) @(negedge clk);
        check("b2b_ready_low_mid", 64'(tx_ready), 64'(0));
        tx_valid = 1'b1;
        tx_data  = W'(32'h33333333);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (2 * LAT) @(negedge clk);
        check("b2b_rx_count", 64'(rx_cnt - snap), 64'(2));
        check("b2b_idle", 64'(busy), 64'(0));
        check("b2b_slave_words", 64'(s_q.size() - s_base), 64'(2));
        if (s_q.size() >= s_base + 2) begin
            check("b2b_word1", 64'(s_q[s_base]), 64'(W'(32'h11111111)));
            check("b2b_word2", 64'(s_q[s_base+1]), 64'(W'(32'h22222222)));
        end
`ifdef SPI_LOOPBACK_EN
        check("b2b_rx_data", 64'(rx_data), 64'(W'(32'h22222222)));
`else
        check("b2b_rx_data", 64'(rx_data), 64'(W'(32'h5A5AC3C3)));
`endif
        check("b2b_gap_seen", 64'(gaps.size() > g_base), 64'(1));
        if (gaps.size() > g_base) check("b2b_cs_gap", 64'(gaps[g_base] >= 1), 64'(1));

        // Asynchronous reset in the middle of a mode-3 transfer.
        @(negedge clk);
        cpol   = 1'b1;
        cpha   = 1'b1;
        m_cpha = 1'b1;
        s_word = W'(32'hDEADBEEF);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = W'(32'h0BADF00D);
        cs_sel   = CS_W'(1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        cyc = 0;
        while (s_nedge < RST_EDGE && cyc < LAT + 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("rst_edge_reached", 64'(s_nedge), 64'(RST_EDGE));
        #2 rst = 1'b1;
        #1;
        check("abort_sclk", 64'(sclk), 64'(0));
        check("abort_mosi", 64'(mosi), 64'(0));
        check("abort_cs_n", 64'(cs_n), 64'({NCS{1'b1}}));
        check("abort_rx_valid", 64'(rx_valid), 64'(0));
        check("abort_rx_data", 64'(rx_data), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_tx_ready", 64'(tx_ready), 64'(1));
        snap = rx_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (LAT) @(negedge clk);
        check("abort_no_rx_valid", 64'(rx_cnt - snap), 64'(0));

        // Clean transfer after the abort.
        xfer(W'(vecs[0].tx), W'(vecs[0].sw), vecs[0].cs, vecs[0].cpol, vecs[0].cpha, vecs[0].exp_cs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
